// File: rtl/dft_pkg.sv
// rtl/dft_pkg.sv - shared constants and FSM state type for the sliding-DFT bin scheduler
package dft_pkg;

    localparam int N_PTS_DEF   = 16;
    localparam int PTR_W_DEF   = 4;
    localparam int NBINS_DEF   = 3;
    localparam int ADDR_W_DEF  = 2;
    localparam int MUL_LAT_DEF = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } sched_state_e;

endpackage

// File: rtl/dft_tag_pipe.sv
// rtl/dft_tag_pipe.sv - valid+tag delay line aligning MAC operand strobes to multiplier writeback
module dft_tag_pipe #(
    parameter int DEPTH = 2,
    parameter int TAG_W = 2
) (
    input  logic             clk,
    input  logic             flush_i,
    input  logic             valid_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             valid_o,
    output logic [TAG_W-1:0] tag_o
);

    logic [DEPTH-1:0] valid_q;
    logic [TAG_W-1:0] tag_q [DEPTH];

    always_ff @(posedge clk) begin
        if (flush_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
            end
        end else begin
            valid_q[0] <= valid_i;
            tag_q[0]   <= tag_i;
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                tag_q[i]   <= tag_q[i-1];
            end
        end
    end

    assign valid_o = valid_q[DEPTH-1];
    assign tag_o   = tag_q[DEPTH-1];

endmodule

// File: rtl/dft_bin_sched.sv
// rtl/dft_bin_sched.sv - per-sample bin sequencer for the sliding-DFT envelope datapath
module dft_bin_sched
    import dft_pkg::*;
#(
    parameter int N_PTS   = N_PTS_DEF,
    parameter int PTR_W   = PTR_W_DEF,
    parameter int NBINS   = NBINS_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int MUL_LAT = MUL_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              samp_valid,
    output logic              samp_ready,
    output logic              dl_rd,
    output logic              dl_wr,
    output logic [PTR_W-1:0]  dl_addr,
    output logic              rom_rd,
    output logic [ADDR_W-1:0] rom_raddr,
    output logic              acc_load,
    output logic [ADDR_W-1:0] acc_bin,
    output logic              wb_en,
    output logic [ADDR_W-1:0] wb_bin,
    output logic              win_full,
    output logic              done,
    output logic              env_valid
);

    localparam logic [ADDR_W-1:0] LAST_BIN = ADDR_W'(NBINS - 1);
    localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(N_PTS - 1);
    localparam logic [PTR_W:0]    CNT_FULL = (PTR_W + 1)'(N_PTS);

    sched_state_e      state_q, state_d;
    logic [ADDR_W-1:0] bin_q;
    logic [PTR_W-1:0]  dl_addr_q;
    logic [PTR_W:0]    cnt_q;
    logic              dl_wr_q, acc_q, done_q;
    logic [ADDR_W-1:0] acc_bin_q;
    logic              wb_v;
    logic [ADDR_W-1:0] wb_t;
    logic              flush, wb_last;

    assign flush   = rst | clr;
    assign wb_last = wb_v && (wb_t == LAST_BIN);

    always_ff @(posedge clk) begin
        if (flush) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (samp_valid && samp_ready) state_d = ISSUE;
            ISSUE:   if (bin_q == LAST_BIN)        state_d = DRAIN;
            DRAIN:   if (wb_last)                  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Every strobe is forced low during rst/clr so an abort is visible in its own cycle.
    always_comb begin
        samp_ready = (state_q == IDLE) && !flush;
        rom_rd     = (state_q == ISSUE) && !flush;
        rom_raddr  = rom_rd ? bin_q : '0;
        dl_rd      = rom_rd && (bin_q == '0);
        dl_wr      = dl_wr_q && !flush;
        dl_addr    = flush ? '0 : dl_addr_q;
        acc_load   = acc_q && !flush;
        acc_bin    = acc_load ? acc_bin_q : '0;
        wb_en      = wb_v && !flush;
        wb_bin     = wb_en ? wb_t : '0;
        done       = done_q && !flush;
        win_full   = !flush && ((cnt_q == CNT_FULL) ||
                                (done_q && (cnt_q == CNT_FULL - 1'b1)));
        env_valid  = done && win_full;
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            bin_q     <= '0;
            dl_addr_q <= '0;
            cnt_q     <= '0;
            dl_wr_q   <= 1'b0;
            acc_q     <= 1'b0;
            acc_bin_q <= '0;
            done_q    <= 1'b0;
        end else begin
            bin_q     <= ((state_q == ISSUE) && (bin_q != LAST_BIN)) ? bin_q + ADDR_W'(1) : '0;
            dl_wr_q   <= dl_rd;
            acc_q     <= rom_rd;
            acc_bin_q <= rom_raddr;
            done_q    <= wb_last;
            if (done_q) begin
                dl_addr_q <= (dl_addr_q == LAST_PTR) ? '0 : dl_addr_q + PTR_W'(1);
                if (cnt_q != CNT_FULL) cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    dft_tag_pipe #(
        .DEPTH (MUL_LAT),
        .TAG_W (ADDR_W)
    ) u_wb_pipe (
        .clk     (clk),
        .flush_i (flush),
        .valid_i (acc_load),
        .tag_i   (acc_bin),
        .valid_o (wb_v),
        .tag_o   (wb_t)
    );

endmodule
